// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// uart_cmd_decoder : turns UART byte frames into RF write/read and ALU strobes.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.   Rev 1.0
// ============================================================================
module uart_cmd_decoder #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int FUN_WIDTH     = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES,
  output logic                     RF_WrEn,
  output logic                     RF_RdEn,
  output logic [ADDR_WIDTH-1:0]    RF_Address,
  output logic [DATA_WIDTH-1:0]    RF_WrData,
  output logic                     ALU_EN,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     CMD_BUSY,
  output logic                     FRAME_ERR
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_OP_A    = 3'd4;
  localparam logic [2:0] S_OP_B    = 3'd5;
  localparam logic [2:0] S_ALU_FUN = 3'd6;

  localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_W = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU   = DATA_WIDTH'(8'hDD);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  alu_en_q, alu_en_d;
  logic                  frame_err_q, frame_err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  timeout_hit;

`ifdef CMD_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmr_q, tmr_d, tmr_next;

  // A byte arriving in the would-be timeout cycle takes priority over the timeout.
  always_comb begin
    tmr_next    = tmr_q + TIMEOUT_WIDTH'(1);
    timeout_hit = !RX_D_VLD && (state_q != S_IDLE) &&
                  (TIMEOUT_CYCLES != '0) && (tmr_next == TIMEOUT_CYCLES);
    tmr_d       = (RX_D_VLD || (state_q == S_IDLE) || timeout_hit) ? '0 : tmr_next;
  end

  always_ff @(posedge CLK) begin
    if (!RST) tmr_q <= '0;
    else      tmr_q <= tmr_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_lat_d  = addr_lat_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    alu_en_d    = 1'b0;
    frame_err_d = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    alu_fun_d   = alu_fun_q;
    if (RX_D_VLD) begin
      case (state_q)
        S_IDLE: begin
          case (RX_P_DATA)
            OP_WRITE: state_d = S_WR_ADDR;
            OP_READ:  state_d = S_RD_ADDR;
            OP_ALU_W: state_d = S_OP_A;
            OP_ALU:   state_d = S_ALU_FUN;
            default:  frame_err_d = 1'b1;
          endcase
        end
        S_WR_ADDR: begin
          addr_lat_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d    = S_WR_DATA;
        end
        S_WR_DATA: begin
          wr_en_d   = 1'b1;
          addr_d    = addr_lat_q;
          wr_data_d = RX_P_DATA;
          state_d   = S_IDLE;
        end
        S_RD_ADDR: begin
          rd_en_d = 1'b1;
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = S_IDLE;
        end
        S_OP_A: begin
          wr_en_d   = 1'b1;
          addr_d    = ADDR_WIDTH'(0);
          wr_data_d = RX_P_DATA;
          state_d   = S_OP_B;
        end
        S_OP_B: begin
          wr_en_d   = 1'b1;
          addr_d    = ADDR_WIDTH'(1);
          wr_data_d = RX_P_DATA;
          state_d   = S_ALU_FUN;
        end
        S_ALU_FUN: begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      addr_lat_q  <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      alu_en_q    <= 1'b0;
      frame_err_q <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      alu_fun_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_lat_q  <= addr_lat_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      alu_en_q    <= alu_en_d;
      frame_err_q <= frame_err_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      alu_fun_q   <= alu_fun_d;
    end
  end

  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_Address = addr_q;
  assign RF_WrData  = wr_data_q;
  assign ALU_EN     = alu_en_q;
  assign ALU_FUN    = alu_fun_q;
  assign FRAME_ERR  = frame_err_q;
  assign CMD_BUSY   = (state_q != S_IDLE);

endmodule
`default_nettype wire
